// File: rtl/ttc_pkg.sv
// ttc_pkg: shared mode encodings and FSM state type for the truth-table checker.
//   MODE_AND/OR/XOR/NAND : 2-bit reference-function selectors
//   state_t              : checker FSM states
package ttc_pkg;
    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational reference for an N-input single-output gate.
//   mode     in  2  reference function select (ttc_pkg MODE_*)
//   vec      in  N  input vector
//   expected out 1  reference output for vec under mode
module gate_ref_model
    import ttc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [1:0]   mode,
    input  logic [N-1:0] vec,
    output logic         expected
);
    always_comb
        expected = mode == MODE_AND ? &vec :
                   mode == MODE_OR  ? |vec :
                   mode == MODE_XOR ? ^vec : ~&vec;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive sweep of an N-input gate against a reference function.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, mode       begin a sweep (IDLE/DONE only), reference function latched on start
//   dut_in, dut_out   registered vector to the gate under test, its response
//   busy, done, pass  sweep running, sweep complete, complete with no mismatches
//   err_count         saturating mismatch count for the current sweep
//   first_fail_valid, first_fail_vec  first mismatching vector, if any
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [N-1:0]     dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [N-1:0]     first_fail_vec
);
    localparam int CW = SETTLE < 1 ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SET_C = CW'(SETTLE);
    // one spare bit so the last-vector test never relies on wrap-around
    localparam logic [N:0] LAST = (N+1)'((1 << N) - 1);

    state_t      state, next;
    logic [1:0]  mode_q;
    logic [N:0]  vec;
    logic [CW-1:0] cnt;
    logic        expected, accept, check, last, mism;

    gate_ref_model #(.N(N)) u_ref (
        .mode     (mode_q),
        .vec      (vec[N-1:0]),
        .expected (expected)
    );

    assign accept = start && state != RUN;
    assign check  = state == RUN && cnt == SET_C;
    assign last   = vec == LAST;
    assign mism   = check && (dut_out != expected);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;

    always_comb
        next = accept ? RUN : (check && last) ? DONE : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q           <= MODE_AND;
            vec              <= '0;
            cnt              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (accept) begin
            mode_q           <= mode;
            vec              <= '0;
            cnt              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (state == RUN) begin
            if (mism) begin
                err_count <= &err_count ? err_count : err_count + ERR_W'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec[N-1:0];
                end
            end
            if (check) begin
                if (!last) begin
                    vec <= vec + (N+1)'(1);
                    cnt <= '0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign dut_in = vec[N-1:0];
    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign pass   = done && err_count == '0;
endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable, parametrised exhaustive truth-table checker for an N-input single-output gate. On `start` it sweeps every input vector 0 … 2^N−1 into the device under test, waits a programmable settle time, and compares the DUT output against a built-in reference function (AND/OR/XOR/NAND). It counts mismatches, captures the first failing vector and reports pass/fail. It generalises the team's 2-input AND stimulus/check flow into hardware, so gate-level blocks can self-test on silicon or in long regressions without a hand-written bench per gate.

## Interface
Parameters:
- `N`, 2, number of DUT inputs (1…16)
- `SETTLE`, 2, cycles between driving a vector and sampling `dut_out` (≥1)
- `ERR_W`, 8, width of the mismatch counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE
- `mode`  in  2  reference function: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on accepted `start`
- `dut_in`  out  N  vector driven to the DUT (registered)
- `dut_out`  in  1  DUT response
- `busy`  out  1  sweep in progress
- `done`  out  1  sweep complete, held until next accepted `start`
- `pass`  out  1  valid while `done`; 1 iff `err_count` == 0
- `err_count`  out  ERR_W  mismatches this sweep, saturating at 2^ERR_W−1
- `first_fail_valid`  out  1  at least one mismatch captured
- `first_fail_vec`  out  N  vector of the first mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + `start`=1 → RUN: latch `mode`; clear `err_count`, `first_fail_*`, `done`, `pass`; `dut_in` ← 0; settle counter ← 0.
- RUN: settle counter counts 0…SETTLE. At count SETTLE (check cycle), compare `dut_out` with ref(mode, `dut_in`):
  - mismatch: `err_count` += 1 unless saturated; if `first_fail_valid`=0, capture `dut_in` into `first_fail_vec` and set `first_fail_valid`.
  - if `dut_in` == 2^N−1 → DONE; else `dut_in` += 1 and counter ← 0.
- DONE: `busy`=0, `done`=1, `pass` = (`err_count`==0). `dut_in` holds the last vector.
- `start` during RUN is ignored; `mode` changes during RUN have no effect.
- Vector counter is N+1 bits internally, so the last-vector test does not depend on wrap-around; `dut_in` never wraps to 0 within a sweep.
- Reference: AND = &v, OR = |v, XOR = ^v, NAND = ~&v.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_valid`=0, `first_fail_vec`=0, state IDLE.
- Reset asserted mid-sweep aborts immediately to the reset values; no partial results are retained.
- `start` accepted at edge E0: `busy`=1 and `dut_in`=0 from E0.
- Each vector is stable for SETTLE+1 cycles; `dut_out` is sampled at the edge ending the last of them.
- Sweep length: 2^N·(SETTLE+1) cycles; `done`=1 and `busy`=0 from the edge after the final check.
- `err_count` and `first_fail_*` update one edge after their check cycle.

## Structure
- Shared package `ttc_pkg`: mode encoding constants (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND) and the FSM state enum.
- Sub-module `gate_ref_model`: combinational (mode, vector) → expected bit, parametrised by N; reused by future gate benches.
- Top level: FSM, settle counter, vector counter, error/capture registers.

## Test plan
- N=2, SETTLE=2, AND mode, correct AND DUT → `done` after 12 cycles, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- N=2, AND mode, DUT stuck-at-1 → `err_count`=3, `first_fail_vec`=00, `pass`=0.
- N=3, XOR mode, AND DUT → `err_count`=3, `first_fail_vec`=001.
- N=3, ERR_W=2, AND mode, NAND DUT → 8 mismatches, `err_count` saturates at 3, `first_fail_vec`=000.
- Pulse `start` and change `mode` mid-sweep → sweep unaffected and length unchanged; a second `start` in DONE reruns with cleared results.
- Deassert `rst_n` at vector 2 → all outputs return to reset values asynchronously; a new `start` runs a full clean sweep.
